alu_seq: RTL and testbench

//   Handshaked, parametrised successor to the combinational ALU. Same {mode_sel, alu_option} op map.

---
 rtl/alu_pkg.sv | 12 +
 rtl/alu_seq_div.sv | 45 ++++
 rtl/alu_seq.sv | 148 ++++++++++++++
 tb/tb_alu_seq.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: mode/opcode encodings and FSM states shared by alu_seq and its divider.
package alu_pkg;
    typedef enum logic [1:0] {MODE_ARITH = 2'b00, MODE_LOGIC = 2'b01, MODE_CMP = 2'b10, MODE_RSVD = 2'b11} mode_e;
    localparam logic [3:0] OP_ADD  = 4'd0, OP_SUB  = 4'd1, OP_MUL  = 4'd2, OP_DIV  = 4'd3, OP_REM = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd0, OP_OR   = 4'd1, OP_XOR  = 4'd2, OP_NOTA = 4'd3;
    localparam logic [3:0] OP_NOTB = 4'd4, OP_NAND = 4'd5, OP_NOR  = 4'd6, OP_XNOR = 4'd7;
    localparam logic [3:0] OP_EQ   = 4'd0, OP_NE   = 4'd1, OP_SLT  = 4'd2, OP_SGE  = 4'd3;
    localparam logic [3:0] OP_ULT  = 4'd4, OP_UGE  = 4'd5, OP_SLL  = 4'd6, OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8, OP_SLT2 = 4'd9, OP_ULT2 = 4'd10;
    typedef logic [1:0] state_e;
    localparam state_e ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_HOLD = 2'd2;
endpackage

// File: rtl/alu_seq_div.sv
// alu_seq_div: restoring divider, one quotient bit per cycle, WIDTH iterations after start.
module alu_seq_div #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   tmp, sub;
    logic             ge;
    assign tmp = {rem_q, quo_q[WIDTH-1]};
    assign sub = tmp - {1'b0, dvs_q};
    assign ge  = tmp >= {1'b0, dvs_q};
    // quotient/remainder are the post-step values, valid in the cycle done is high
    assign remainder = ge ? sub[WIDTH-1:0] : tmp[WIDTH-1:0];
    assign quotient  = {quo_q[WIDTH-2:0], ge};
    assign busy = cnt != '0;
    assign done = cnt == CW'(1);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt   <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (start) begin
            cnt   <= CW'(WIDTH);
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (busy) begin
            cnt   <= cnt - CW'(1);
            rem_q <= remainder;
            quo_q <= quotient;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU, registered 1-cycle simple ops, iterative DIV/REM.
// Define ALU_FLAGS_EN to add the registered {ovf, neg, zero, div0} flags port.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [3:0]       alu_option,
    input  logic [1:0]       mode_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_data,
    output logic             Cout,
    output logic             illegal
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]       flags
`endif
);
    localparam logic [WIDTH:0] W_V = (WIDTH + 1)'(WIDTH);
    state_e                  state;
    logic                    accept, is_div, ill, c, rem_sel, big;
    logic                    div_start, div_busy, div_done;
    logic [WIDTH-1:0]        res, div_quo, div_rem, dres;
    logic [WIDTH:0]          sum, diff;
    logic [2*WIDTH-1:0]      prod;
    logic [SHAMT_W-1:0]      sh;
    logic signed [WIDTH-1:0] sra_v;
    assign in_ready  = !rst_i && (state == ST_IDLE || (state == ST_HOLD && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = state == ST_HOLD;
    assign div_start = accept && is_div;
    assign sum  = {1'b0, operand_a} + {1'b0, operand_b};
    assign diff = {1'b0, operand_a} - {1'b0, operand_b};
    assign prod = {{WIDTH{1'b0}}, operand_a} * {{WIDTH{1'b0}}, operand_b};
    // the full operand_b decides saturation; only the low bits drive the shifter
    assign sh    = operand_b[SHAMT_W-1:0];
    assign big   = {1'b0, operand_b} >= W_V;
    assign sra_v = $signed(operand_a) >>> sh;
    assign dres  = rem_sel ? div_rem : div_quo;
    always_comb begin
        res    = '0;
        c      = 1'b0;
        ill    = 1'b0;
        is_div = 1'b0;
        case (mode_e'(mode_sel))
            MODE_ARITH: case (alu_option)
                OP_ADD: begin
                    res = sum[WIDTH-1:0];
                    c   = sum[WIDTH];
                end
                OP_SUB: begin
                    res = diff[WIDTH-1:0];
                    c   = diff[WIDTH];
                end
                OP_MUL: begin
                    res = prod[WIDTH-1:0];
                    c   = |prod[2*WIDTH-1:WIDTH];
                end
                OP_DIV, OP_REM: is_div = 1'b1;
                default: ill = 1'b1;
            endcase
            MODE_LOGIC: case (alu_option)
                OP_AND:  res = operand_a & operand_b;
                OP_OR:   res = operand_a | operand_b;
                OP_XOR:  res = operand_a ^ operand_b;
                OP_NOTA: res = ~operand_a;
                OP_NOTB: res = ~operand_b;
                OP_NAND: res = ~(operand_a & operand_b);
                OP_NOR:  res = ~(operand_a | operand_b);
                OP_XNOR: res = ~(operand_a ^ operand_b);
                default: ill = 1'b1;
            endcase
            MODE_CMP: case (alu_option)
                OP_EQ:           res = WIDTH'(operand_a == operand_b);
                OP_NE:           res = WIDTH'(operand_a != operand_b);
                OP_SLT, OP_SLT2: res = WIDTH'($signed(operand_a) < $signed(operand_b));
                OP_SGE:          res = WIDTH'($signed(operand_a) >= $signed(operand_b));
                OP_ULT, OP_ULT2: res = WIDTH'(operand_a < operand_b);
                OP_UGE:          res = WIDTH'(operand_a >= operand_b);
                OP_SLL:          res = big ? '0 : operand_a << sh;
                OP_SRL:          res = big ? '0 : operand_a >> sh;
                OP_SRA:          res = big ? {WIDTH{operand_a[WIDTH-1]}} : sra_v;
                default:         ill = 1'b1;
            endcase
            default: ill = 1'b1;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            alu_data <= '0;
            Cout     <= 1'b0;
            illegal  <= 1'b0;
            rem_sel  <= 1'b0;
        end else if (accept) begin
            state   <= is_div ? ST_BUSY : ST_HOLD;
            rem_sel <= alu_option == OP_REM;
            if (!is_div) begin
                alu_data <= res;
                Cout     <= c;
                illegal  <= ill;
            end
        end else if (div_busy && div_done) begin
            state    <= ST_HOLD;
            alu_data <= dres;
            Cout     <= 1'b0;
            illegal  <= 1'b0;
        end else if (state == ST_HOLD && out_ready) begin
            state <= ST_IDLE;
        end
    end
`ifdef ALU_FLAGS_EN
    logic ovf, div0_r;
    assign ovf = mode_sel == MODE_ARITH &&
        ((alu_option == OP_ADD && operand_a[WIDTH-1] == operand_b[WIDTH-1] && sum[WIDTH-1] != operand_a[WIDTH-1]) ||
         (alu_option == OP_SUB && operand_a[WIDTH-1] != operand_b[WIDTH-1] && diff[WIDTH-1] != operand_a[WIDTH-1]));
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flags  <= '0;
            div0_r <= 1'b0;
        end else if (accept) begin
            div0_r <= operand_b == '0;
            if (!is_div) flags <= {ovf, res[WIDTH-1], res == '0, 1'b0};
        end else if (div_busy && div_done) begin
            flags <= {1'b0, dres[WIDTH-1], dres == '0, div0_r};
        end
    end
`endif
    alu_seq_div #(.WIDTH(WIDTH)) u_div (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start     (div_start),
        .dividend  (operand_a),
        .divisor   (operand_b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against an integer reference model.
module tb_alu_seq;
    localparam int W = 4;
    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic [3:0]   alu_option = '0;
    logic [1:0]   mode_sel = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] alu_data;
    logic         Cout;
    logic         illegal;
`ifdef ALU_FLAGS_EN
    logic [3:0]   flags;
`endif
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    alu_seq #(.WIDTH(W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .alu_option (alu_option),
        .mode_sel   (mode_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_data   (alu_data),
        .Cout       (Cout),
        .illegal    (illegal)
`ifdef ALU_FLAGS_EN
        ,
        .flags      (flags)
`endif
    );

    typedef struct {
        int data;
        int cout;
        int ill;
        int flags;
        int lat;
    } exp_t;

    function automatic exp_t model(input int mode, input int opt, input int a, input int b);
        exp_t e;
        int   m = 1 << W;
        int   sa, sb, r;
        int   ovf = 0;
        int   div0 = 0;
        e.cout = 0;
        e.ill = 0;
        e.lat = 1;
        r = 0;
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        case (mode)
            0: case (opt)
                0: begin r = a + b; e.cout = r >= m; ovf = (sa + sb > m / 2 - 1) || (sa + sb < -m / 2); end
                1: begin r = a - b; e.cout = a < b; ovf = (sa - sb > m / 2 - 1) || (sa - sb < -m / 2); end
                2: begin r = a * b; e.cout = r >= m; end
                3: begin r = (b == 0) ? m - 1 : a / b; div0 = b == 0; e.lat = W + 1; end
                4: begin r = (b == 0) ? a : a % b; div0 = b == 0; e.lat = W + 1; end
                default: e.ill = 1;
            endcase
            1: case (opt)
                0: r = a & b;
                1: r = a | b;
                2: r = a ^ b;
                3: r = m - 1 - a;
                4: r = m - 1 - b;
                5: r = m - 1 - (a & b);
                6: r = m - 1 - (a | b);
                7: r = m - 1 - (a ^ b);
                default: e.ill = 1;
            endcase
            2: case (opt)
                0: r = a == b;
                1: r = a != b;
                2, 9: r = sa < sb;
                3: r = sa >= sb;
                4, 10: r = a < b;
                5: r = a >= b;
                6: r = (b >= W) ? 0 : a << b;
                7: r = (b >= W) ? 0 : a >> b;
                8: r = (b >= W) ? ((sa < 0) ? -1 : 0) : sa >>> b;
                default: e.ill = 1;
            endcase
            default: e.ill = 1;
        endcase
        e.data = e.ill ? 0 : (r & (m - 1));
        e.flags = (ovf << 3) | (int'(e.data >= m / 2) << 2) | (int'(e.data == 0) << 1) | div0;
        return e;
    endfunction

    task automatic run_op(input int mode, input int opt, input int a, input int b,
                          output int d, output int c, output int il, output int fl, output int lat);
        int n = 0;
        @(negedge clk_i);
        mode_sel = mode[1:0];
        alu_option = opt[3:0];
        operand_a = a[W-1:0];
        operand_b = b[W-1:0];
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        @(negedge clk_i);
        in_valid = 1'b0;
        operand_a = W'($urandom);
        operand_b = W'($urandom);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk_i);
            lat++;
        end
        d = int'(alu_data);
        c = int'(Cout);
        il = int'(illegal);
`ifdef ALU_FLAGS_EN
        fl = int'(flags);
`else
        fl = 0;
`endif
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        n_cmp++;
        if ({out_valid, alu_data, Cout, illegal, in_ready} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got v=%b d=%h c=%b il=%b rdy=%b want all 0", out_valid, alu_data, Cout, illegal, in_ready);
        end
        rst_i = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        // mode, opt, a, b, data, cout, illegal, latency, flags
        int tbl[11][9] = '{
            '{0, 0,  9,  8,  1, 1, 0, 1, 4'b1000},
            '{0, 3, 13,  3,  4, 0, 0, 5, 4'b0000},
            '{0, 4, 13,  3,  1, 0, 0, 5, 4'b0000},
            '{0, 3,  7,  0, 15, 0, 0, 5, 4'b0101},
            '{0, 4,  7,  0,  7, 0, 0, 5, 4'b0001},
            '{2, 8,  8,  5, 15, 0, 0, 1, 4'b0100},
            '{2, 6,  3,  4,  0, 0, 0, 1, 4'b0010},
            '{2, 2, 15,  1,  1, 0, 0, 1, 4'b0000},
            '{3, 0,  5,  6,  0, 0, 1, 1, 4'b0010},
            '{0, 2,  5,  4,  4, 1, 0, 1, 4'b0000},
            '{0, 1,  2,  3, 15, 1, 0, 1, 4'b0100}};
        int d, c, il, fl, lat;
        for (int i = 0; i < 11; i++) begin
            run_op(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], d, c, il, fl, lat);
            n_cmp++;
            if (d !== tbl[i][4] || c !== tbl[i][5] || il !== tbl[i][6] || lat !== tbl[i][7]) begin
                n_bad++;
                $display("FAIL directed[%0d]: got d=%0d c=%0d il=%0d lat=%0d want d=%0d c=%0d il=%0d lat=%0d",
                         i, d, c, il, lat, tbl[i][4], tbl[i][5], tbl[i][6], tbl[i][7]);
            end
`ifdef ALU_FLAGS_EN
            n_cmp++;
            if (fl !== tbl[i][8]) begin
                n_bad++;
                $display("FAIL directed_flags[%0d]: got %b want %b", i, fl[3:0], tbl[i][8]);
            end
`endif
        end
    endtask

    task automatic test_div_busy();
        int n = 0;
        @(negedge clk_i);
        mode_sel = 2'b00;
        alu_option = 4'd3;
        operand_a = 4'd13;
        operand_b = 4'd3;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        @(negedge clk_i);
        alu_option = 4'd0;
        operand_a = 4'd9;
        operand_b = 4'd8;
        for (int i = 0; i < W; i++) begin
            #1;
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL div_busy[%0d]: got rdy=%b v=%b want 0 0", i, in_ready, out_valid);
            end
            @(negedge clk_i);
        end
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || alu_data !== 4'd4 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL div_done: got v=%b d=%0d rdy=%b want 1 4 1", out_valid, alu_data, in_ready);
        end
        @(negedge clk_i);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || alu_data !== 4'd1 || Cout !== 1'b1) begin
            n_bad++;
            $display("FAIL div_then_add: got v=%b d=%0d c=%b want 1 1 1", out_valid, alu_data, Cout);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        @(negedge clk_i);
        mode_sel = 2'b00;
        alu_option = 4'd0;
        operand_a = 4'd5;
        operand_b = 4'd6;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        @(negedge clk_i);
        out_ready = 1'b0;
        alu_option = 4'd1;
        operand_a = 4'd9;
        operand_b = 4'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (out_valid !== 1'b1 || alu_data !== 4'd11 || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL hold[%0d]: got v=%b d=%0d rdy=%b want 1 11 0", i, out_valid, alu_data, in_ready);
            end
            @(negedge clk_i);
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || alu_data !== 4'd11) begin
            n_bad++;
            $display("FAIL drain_accept: got rdy=%b d=%0d want 1 11", in_ready, alu_data);
        end
        @(negedge clk_i);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || alu_data !== 4'd7) begin
            n_bad++;
            $display("FAIL after_drain: got v=%b d=%0d want 1 7", out_valid, alu_data);
        end
    endtask

    task automatic test_back_to_back();
        exp_t q[$];
        exp_t e;
        int   mode, opt, a, b;
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk_i);
            if (i > 0) begin
                e = q.pop_front();
                n_cmp++;
                if (out_valid !== 1'b1 || int'(alu_data) !== e.data || int'(Cout) !== e.cout || int'(illegal) !== e.ill) begin
                    n_bad++;
                    $display("FAIL b2b[%0d]: got v=%b d=%0d c=%b il=%b want 1 %0d %0d %0d",
                             i, out_valid, alu_data, Cout, illegal, e.data, e.cout, e.ill);
                end
            end
            if (i < 20) begin
                mode = int'($urandom_range(3, 0));
                opt = int'($urandom_range(15, 0));
                if (mode == 0 && (opt == 3 || opt == 4)) opt = 2;
                a = int'($urandom_range(15, 0));
                b = int'($urandom_range(15, 0));
                mode_sel = mode[1:0];
                alu_option = opt[3:0];
                operand_a = a[W-1:0];
                operand_b = b[W-1:0];
                in_valid = 1'b1;
                out_ready = 1'b1;
                q.push_back(model(mode, opt, a, b));
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_busy();
        int n = 0;
        int d, c, il, fl, lat;
        @(negedge clk_i);
        mode_sel = 2'b00;
        alu_option = 4'd3;
        operand_a = 4'd13;
        operand_b = 4'd3;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        @(negedge clk_i);
        in_valid = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_data !== '0 || Cout !== 1'b0 || illegal !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_busy: got v=%b rdy=%b d=%0d c=%b il=%b want 0 1 0 0 0", out_valid, in_ready, alu_data, Cout, illegal);
        end
`ifdef ALU_FLAGS_EN
        n_cmp++;
        if (flags !== 4'b0) begin
            n_bad++;
            $display("FAIL rst_flags: got %b want 0000", flags);
        end
`endif
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk_i);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL stale_div[%0d]: got v=%b want 0", i, out_valid);
            end
        end
        run_op(3, 0, 5, 9, d, c, il, fl, lat);
        n_cmp++;
        if (il !== 1 || d !== 0 || c !== 0 || lat !== 1) begin
            n_bad++;
            $display("FAIL illegal_after_rst: got il=%0d d=%0d c=%0d lat=%0d want 1 0 0 1", il, d, c, lat);
        end
    endtask

    task automatic test_random();
        exp_t e;
        int   mode, opt, a, b;
        int   d, c, il, fl, lat;
        for (int i = 0; i < 80; i++) begin
            mode = int'($urandom_range(3, 0));
            opt = int'($urandom_range(i % 2 == 0 ? 15 : 10, 0));
            a = int'($urandom_range(15, 0));
            b = int'($urandom_range(15, 0));
            e = model(mode, opt, a, b);
            run_op(mode, opt, a, b, d, c, il, fl, lat);
            n_cmp++;
            if (d !== e.data || c !== e.cout || il !== e.ill || lat !== e.lat) begin
                n_bad++;
                $display("FAIL rand[%0d] m=%0d o=%0d a=%0d b=%0d: got d=%0d c=%0d il=%0d lat=%0d want d=%0d c=%0d il=%0d lat=%0d",
                         i, mode, opt, a, b, d, c, il, lat, e.data, e.cout, e.ill, e.lat);
            end
`ifdef ALU_FLAGS_EN
            n_cmp++;
            if (fl !== e.flags) begin
                n_bad++;
                $display("FAIL rand_flags[%0d] m=%0d o=%0d a=%0d b=%0d: got %b want %b", i, mode, opt, a, b, fl[3:0], e.flags[3:0]);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_busy();
        test_backpressure();
        test_back_to_back();
        test_reset_busy();
        test_random();
        repeat (2) @(negedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
